// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial BCD-to-binary converter.
// Defining BCD_DIGIT_CHECK_EN enables per-digit range checking in the top.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam int BCD_MAX_DIGIT = 9;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        DONE
    } conv_state_t;

endpackage

// File: rtl/bcd_to_binary_serial_mul10_add.sv
// One Horner step: result = acc*10 + digit, with acc*10 built from two shifts.
// Kept standalone so the forward converter's tests can reuse it.
module mul10_add
    import bcd_pkg::*;
#(
    parameter int AccWidth = 36
) (
    input  logic [AccWidth-1:0] acc_i,
    input  bcd_digit_t          digit_i,
    output logic [AccWidth-1:0] result_o
);

    assign result_o = (acc_i << 3) + (acc_i << 1) + {{(AccWidth-4){1'b0}}, digit_i};

endmodule

// File: rtl/bcd_to_binary_serial.sv
// Serial BCD-to-binary converter, one digit per clock, most-significant digit first.
// Optional macro BCD_DIGIT_CHECK_EN flags digits above 9 on digitError.
module bcd_to_binary_serial
    import bcd_pkg::*;
#(
    parameter int binaryNumberWidth = 32,
    parameter int numberOfDigits    = 3
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                load,
    input  logic [numberOfDigits-1:0][3:0]      BinaryDecimal,
    output logic [binaryNumberWidth-1:0]        binaryNumber,
    output logic                                busy,
    output logic                                done,
    output logic                                overflow,
    output logic                                digitError
);

    localparam int AccWidth  = binaryNumberWidth + 4;
    localparam int DigitBits = 4 * numberOfDigits;
    localparam int CntWidth  = (numberOfDigits > 1) ? $clog2(numberOfDigits) : 1;

    conv_state_t                    state_q, state_d;
    logic [binaryNumberWidth-1:0]   acc_q, acc_d;
    logic [DigitBits-1:0]           digits_q, digits_d;
    logic [CntWidth-1:0]            cnt_q, cnt_d;
    logic [binaryNumberWidth-1:0]   result_q, result_d;
    logic                           ovf_q, ovf_d;
    logic                           err_q, err_d;

    bcd_digit_t                     topDigit;
    logic [AccWidth-1:0]            accWide;
    logic [AccWidth-1:0]            stepAcc;
    logic                           digitBad;
    logic                           accept;

    assign topDigit = digits_q[DigitBits-1 -: 4];

    // The stored accumulator keeps only the low bits: once overflow is flagged
    // the value is carried modulo 2^binaryNumberWidth, and the upper nibble of
    // each step result is only needed to detect that overflow.
    assign accWide = {4'b0000, acc_q};

    mul10_add #(
        .AccWidth (AccWidth)
    ) u_mul10_add (
        .acc_i    (accWide),
        .digit_i  (topDigit),
        .result_o (stepAcc)
    );

`ifdef BCD_DIGIT_CHECK_EN
    assign digitBad = (topDigit > 4'(BCD_MAX_DIGIT));
`else
    assign digitBad = 1'b0;
`endif

    assign accept = load && ((state_q == IDLE) || (state_q == DONE));

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        digits_d = digits_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        err_d    = err_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = accept ? CONVERT : IDLE;
            end
            CONVERT: begin
                acc_d    = stepAcc[binaryNumberWidth-1:0];
                digits_d = digits_q << 4;
                cnt_d    = cnt_q - 1'b1;
                ovf_d    = ovf_q | (|stepAcc[AccWidth-1:binaryNumberWidth]);
                err_d    = err_q | digitBad;
                if (cnt_q == '0) begin
                    result_d = stepAcc[binaryNumberWidth-1:0];
                    state_d  = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            acc_d    = '0;
            digits_d = BinaryDecimal;
            cnt_d    = CntWidth'(numberOfDigits - 1);
            ovf_d    = 1'b0;
            err_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            digits_q <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            digits_q <= digits_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

    assign binaryNumber = result_q;
    assign busy         = (state_q == CONVERT);
    assign done         = (state_q == DONE);
    assign overflow     = ovf_q;
    assign digitError   = err_q;

endmodule

// File: tb/tb_bcd_to_binary_serial.sv
// Directed bench for bcd_to_binary_serial: default, 8-bit-overflow and single-digit instances.
// Expects digitError=1 on the bad-digit vector only when BCD_DIGIT_CHECK_EN is defined.
module tb_bcd_to_binary_serial;

    logic        clk = 1'b0;
    logic        rst;

    logic        loadA;
    logic [2:0][3:0] bcdA;
    logic [31:0] binA;
    logic        busyA, doneA, ovfA, errA;

    logic        loadB;
    logic [2:0][3:0] bcdB;
    logic [7:0]  binB;
    logic        busyB, doneB, ovfB, errB;

    logic        loadC;
    logic [0:0][3:0] bcdC;
    logic [7:0]  binC;
    logic        busyC, doneC, ovfC, errC;

    int vectorCount = 0;
    int missCount   = 0;

    always #5 clk = ~clk;

    bcd_to_binary_serial #(.binaryNumberWidth(32), .numberOfDigits(3)) dutA (
        .clk(clk), .rst(rst), .load(loadA), .BinaryDecimal(bcdA),
        .binaryNumber(binA), .busy(busyA), .done(doneA),
        .overflow(ovfA), .digitError(errA)
    );

    bcd_to_binary_serial #(.binaryNumberWidth(8), .numberOfDigits(3)) dutB (
        .clk(clk), .rst(rst), .load(loadB), .BinaryDecimal(bcdB),
        .binaryNumber(binB), .busy(busyB), .done(doneB),
        .overflow(ovfB), .digitError(errB)
    );

    bcd_to_binary_serial #(.binaryNumberWidth(8), .numberOfDigits(1)) dutC (
        .clk(clk), .rst(rst), .load(loadC), .BinaryDecimal(bcdC),
        .binaryNumber(binC), .busy(busyC), .done(doneC),
        .overflow(ovfC), .digitError(errC)
    );

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [11:0] bcd, input logic ld);
        bcdA  = bcd;
        loadA = ld;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        assert (observed === expected)
        else begin
            missCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        rst   = 1'b1;
        loadA = 1'b0; bcdA = '0;
        loadB = 1'b0; bcdB = '0;
        loadC = 1'b0; bcdC = '0;
        tick();
        tick();
        rst = 1'b0;

        checkOutput("reset busyA", {31'd0, busyA}, 32'd0);
        checkOutput("reset doneA", {31'd0, doneA}, 32'd0);
        checkOutput("reset binA",  binA, 32'd0);
        checkOutput("reset ovfA",  {31'd0, ovfA}, 32'd0);
        checkOutput("reset errA",  {31'd0, errA}, 32'd0);
        checkOutput("reset busyB", {31'd0, busyB}, 32'd0);

        // 0x123 -> 123, busy three cycles, done in the fourth
        applyStimulus(12'h123, 1'b1);
        tick();
        applyStimulus(12'h000, 1'b0);
        checkOutput("123 busy c1", {31'd0, busyA}, 32'd1);
        checkOutput("123 done c1", {31'd0, doneA}, 32'd0);
        tick();
        checkOutput("123 busy c2", {31'd0, busyA}, 32'd1);
        tick();
        checkOutput("123 busy c3", {31'd0, busyA}, 32'd1);
        tick();
        checkOutput("123 done",    {31'd0, doneA}, 32'd1);
        checkOutput("123 busy off", {31'd0, busyA}, 32'd0);
        checkOutput("123 value",   binA, 32'd123);
        checkOutput("123 ovf",     {31'd0, ovfA}, 32'd0);
        tick();
        checkOutput("123 done pulse", {31'd0, doneA}, 32'd0);
        checkOutput("123 held",    binA, 32'd123);

        // 0x999 then 0x000 with load asserted during DONE
        applyStimulus(12'h999, 1'b1);
        tick();
        applyStimulus(12'h000, 1'b0);
        tick();
        tick();
        tick();
        checkOutput("999 done",  {31'd0, doneA}, 32'd1);
        checkOutput("999 value", binA, 32'd999);
        applyStimulus(12'h000, 1'b1);
        tick();
        applyStimulus(12'h000, 1'b0);
        checkOutput("b2b busy",  {31'd0, busyA}, 32'd1);
        tick();
        checkOutput("b2b no done c2", {31'd0, doneA}, 32'd0);
        tick();
        checkOutput("b2b no done c3", {31'd0, doneA}, 32'd0);
        tick();
        checkOutput("000 done",  {31'd0, doneA}, 32'd1);
        checkOutput("000 value", binA, 32'd0);
        tick();

        // 0x456 with an ignored 0x111 load while busy
        applyStimulus(12'h456, 1'b1);
        tick();
        applyStimulus(12'h111, 1'b1);
        tick();
        applyStimulus(12'h000, 1'b0);
        tick();
        tick();
        checkOutput("456 done",  {31'd0, doneA}, 32'd1);
        checkOutput("456 value", binA, 32'd456);
        tick();
        checkOutput("456 idle done", {31'd0, doneA}, 32'd0);
        checkOutput("456 idle busy", {31'd0, busyA}, 32'd0);

        // 0x789 aborted by reset after two CONVERT cycles
        applyStimulus(12'h789, 1'b1);
        tick();
        applyStimulus(12'h000, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abort busy",  {31'd0, busyA}, 32'd0);
        checkOutput("abort done",  {31'd0, doneA}, 32'd0);
        checkOutput("abort value", binA, 32'd0);
        tick();
        checkOutput("abort no done", {31'd0, doneA}, 32'd0);
        applyStimulus(12'h012, 1'b1);
        tick();
        applyStimulus(12'h000, 1'b0);
        tick();
        tick();
        tick();
        checkOutput("012 done",  {31'd0, doneA}, 32'd1);
        checkOutput("012 value", binA, 32'd12);
        tick();

        // Non-BCD digit: 1*100 + 10*10 + 3
        applyStimulus(12'h1A3, 1'b1);
        tick();
        applyStimulus(12'h000, 1'b0);
        tick();
        tick();
        tick();
        checkOutput("1A3 done",  {31'd0, doneA}, 32'd1);
        checkOutput("1A3 value", binA, 32'd203);
`ifdef BCD_DIGIT_CHECK_EN
        checkOutput("1A3 digitError", {31'd0, errA}, 32'd1);
`else
        checkOutput("1A3 digitError", {31'd0, errA}, 32'd0);
`endif
        tick();

        // 8-bit result: 300 wraps to 44 with overflow
        bcdB  = 12'h300;
        loadB = 1'b1;
        tick();
        loadB = 1'b0;
        tick();
        tick();
        tick();
        checkOutput("300 done",  {31'd0, doneB}, 32'd1);
        checkOutput("300 value", {24'd0, binB}, 32'd44);
        checkOutput("300 ovf",   {31'd0, ovfB}, 32'd1);
        tick();
        checkOutput("300 ovf held", {31'd0, ovfB}, 32'd1);

        // 8-bit boundary: 255 fits exactly, overflow clears on the new load
        bcdB  = 12'h255;
        loadB = 1'b1;
        tick();
        loadB = 1'b0;
        checkOutput("255 ovf cleared", {31'd0, ovfB}, 32'd0);
        tick();
        tick();
        tick();
        checkOutput("255 done",  {31'd0, doneB}, 32'd1);
        checkOutput("255 value", {24'd0, binB}, 32'd255);
        checkOutput("255 ovf",   {31'd0, ovfB}, 32'd0);
        tick();

        // Single-digit instance: one CONVERT cycle
        bcdC  = 4'h7;
        loadC = 1'b1;
        tick();
        loadC = 1'b0;
        checkOutput("1dig busy",  {31'd0, busyC}, 32'd1);
        tick();
        checkOutput("1dig done",  {31'd0, doneC}, 32'd1);
        checkOutput("1dig value", {24'd0, binC}, 32'd7);
        tick();
        checkOutput("1dig idle",  {31'd0, doneC}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
